// File: rtl/hv_rac_req_sched.sv
// hv_rac_req_sched: round-robin scheduler for three requesters (SPI, OWT,
// periodic check engine) in front of the register access controller.
// One transaction is latched at a time and held until the matching RAC ack
// or a timeout. The ack and read data go back to the owning requester only.
//
// Handshake: a requester holds its level request (i_spi_*_req, i_owt_vld,
// i_chk_rd_req) until its one-cycle ack output pulses. On the RAC side,
// o_rac_*_req stays high with stable fields until a matching i_rac_wack or
// i_rac_rack arrives, or the timeout expires. Acks that arrive outside the
// access phase, or that do not match the request type, are ignored.
module hv_rac_req_sched #(
    parameter int REG_AW      = 7,
    parameter int REG_DW      = 8,
    parameter int REG_CRC_W   = 8,
    parameter int TIMEOUT_CYC = 16,
    parameter int TO_W        = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_spi_wr_req,
    input  logic                 i_spi_rd_req,
    input  logic [REG_AW-1:0]    i_spi_addr,
    input  logic [REG_DW-1:0]    i_spi_wdata,
    input  logic [REG_CRC_W-1:0] i_spi_wcrc,
    output logic                 o_spi_wack,
    output logic                 o_spi_rack,
    output logic [REG_DW-1:0]    o_spi_rdata,
    input  logic                 i_owt_vld,
    input  logic [REG_AW-1:0]    i_owt_addr,
    input  logic [REG_DW-1:0]    i_owt_wdata,
    input  logic [REG_CRC_W-1:0] i_owt_wcrc,
    output logic                 o_owt_rdy,
    input  logic                 i_chk_rd_req,
    input  logic [REG_AW-1:0]    i_chk_addr,
    output logic                 o_chk_rack,
    output logic [REG_DW-1:0]    o_chk_rdata,
    output logic                 o_rac_wr_req,
    output logic                 o_rac_rd_req,
    output logic [REG_AW-1:0]    o_rac_addr,
    output logic [REG_DW-1:0]    o_rac_wdata,
    output logic [REG_CRC_W-1:0] o_rac_wcrc,
    input  logic                 i_rac_wack,
    input  logic                 i_rac_rack,
    input  logic [REG_DW-1:0]    i_rac_rdata,
    output logic                 o_busy,
    output logic                 o_to_pulse,
    output logic                 o_acc_err,
    input  logic                 i_err_clr
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_SPI  = 2'd1;
    localparam logic [1:0] OWN_OWT  = 2'd2;
    localparam logic [1:0] OWN_CHK  = 2'd3;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic {ST_IDLE, ST_ACC} state_t;

    state_t               r_state;
    logic [1:0]           r_owner;
    logic [1:0]           r_rr_last;
    logic                 r_is_wr;
    logic [TO_W-1:0]      r_to_cnt;
    logic                 r_acc_err;

    logic                 w_spi_pend;
    logic                 w_owt_pend;
    logic                 w_chk_pend;
    logic [1:0]           w_win;
    logic                 w_win_wr;
    logic [REG_AW-1:0]    w_win_addr;
    logic [REG_DW-1:0]    w_win_wdata;
    logic [REG_CRC_W-1:0] w_win_wcrc;
    logic                 w_acc;
    logic                 w_match;
    logic                 w_timeout;
    logic                 w_done;
    logic                 w_own_spi;
    logic                 w_own_owt;
    logic                 w_own_chk;

    assign w_spi_pend = i_spi_wr_req | i_spi_rd_req;
    assign w_owt_pend = i_owt_vld;
    assign w_chk_pend = i_chk_rd_req;

    // Round-robin pick: search starts at the requester after the last winner.
    always_comb begin
        w_win = OWN_NONE;
        case (r_rr_last)
            OWN_SPI: begin
                if (w_owt_pend)      w_win = OWN_OWT;
                else if (w_chk_pend) w_win = OWN_CHK;
                else if (w_spi_pend) w_win = OWN_SPI;
            end
            OWN_OWT: begin
                if (w_chk_pend)      w_win = OWN_CHK;
                else if (w_spi_pend) w_win = OWN_SPI;
                else if (w_owt_pend) w_win = OWN_OWT;
            end
            default: begin
                if (w_spi_pend)      w_win = OWN_SPI;
                else if (w_owt_pend) w_win = OWN_OWT;
                else if (w_chk_pend) w_win = OWN_CHK;
            end
        endcase
    end

    // Fields of the winning requester; SPI with both requests high is a write,
    // and reads carry zero data and CRC.
    always_comb begin
        w_win_wr    = 1'b0;
        w_win_addr  = '0;
        w_win_wdata = '0;
        w_win_wcrc  = '0;
        case (w_win)
            OWN_SPI: begin
                w_win_wr   = i_spi_wr_req;
                w_win_addr = i_spi_addr;
                if (i_spi_wr_req) begin
                    w_win_wdata = i_spi_wdata;
                    w_win_wcrc  = i_spi_wcrc;
                end
            end
            OWN_OWT: begin
                w_win_wr    = 1'b1;
                w_win_addr  = i_owt_addr;
                w_win_wdata = i_owt_wdata;
                w_win_wcrc  = i_owt_wcrc;
            end
            OWN_CHK: begin
                w_win_addr = i_chk_addr;
            end
            default: ;
        endcase
    end

    assign w_acc     = (r_state == ST_ACC);
    assign w_match   = w_acc & (r_is_wr ? i_rac_wack : i_rac_rack);
    assign w_timeout = w_acc & ~w_match & (r_to_cnt == TO_LAST);
    assign w_done    = w_match | w_timeout;

    // Scheduler FSM: grant in IDLE, hold the RAC request in ACC until done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_NONE;
            r_rr_last    <= OWN_CHK;
            r_is_wr      <= 1'b0;
            r_to_cnt     <= '0;
            o_rac_wr_req <= 1'b0;
            o_rac_rd_req <= 1'b0;
            o_rac_addr   <= '0;
            o_rac_wdata  <= '0;
            o_rac_wcrc   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win != OWN_NONE) begin
                        r_owner      <= w_win;
                        r_rr_last    <= w_win;
                        r_is_wr      <= w_win_wr;
                        r_to_cnt     <= '0;
                        o_rac_wr_req <= w_win_wr;
                        o_rac_rd_req <= ~w_win_wr;
                        o_rac_addr   <= w_win_addr;
                        o_rac_wdata  <= w_win_wdata;
                        o_rac_wcrc   <= w_win_wcrc;
                        r_state      <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (w_done) begin
                        o_rac_wr_req <= 1'b0;
                        o_rac_rd_req <= 1'b0;
                        r_owner      <= OWN_NONE;
                        r_to_cnt     <= '0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky access-error flag; a timeout in the same cycle beats a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_acc_err <= 1'b0;
        else if (w_timeout) r_acc_err <= 1'b1;
        else if (i_err_clr) r_acc_err <= 1'b0;
    end

    assign w_own_spi = w_acc & (r_owner == OWN_SPI);
    assign w_own_owt = w_acc & (r_owner == OWN_OWT);
    assign w_own_chk = w_acc & (r_owner == OWN_CHK);

    assign o_spi_wack  = w_own_spi & r_is_wr & w_done;
    assign o_spi_rack  = w_own_spi & ~r_is_wr & w_done;
    assign o_spi_rdata = (w_own_spi & ~r_is_wr & w_match) ? i_rac_rdata : '0;
    assign o_owt_rdy   = w_own_owt & w_done;
    assign o_chk_rack  = w_own_chk & w_done;
    assign o_chk_rdata = (w_own_chk & w_match) ? i_rac_rdata : '0;

    assign o_busy     = w_acc;
    assign o_to_pulse = w_timeout;
    assign o_acc_err  = r_acc_err | w_timeout;

endmodule

// File: tb/tb_hv_rac_req_sched.sv
// Testbench for hv_rac_req_sched: a vector table of single transactions plus
// hand-written sequences for round-robin, timeout, mixed acks and reset.
module tb_hv_rac_req_sched;

    localparam int AW = 7;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int EW = 2 + AW + DW + CW;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_spi_wr_req, i_spi_rd_req;
    logic [AW-1:0] i_spi_addr;
    logic [DW-1:0] i_spi_wdata;
    logic [CW-1:0] i_spi_wcrc;
    logic          o_spi_wack, o_spi_rack;
    logic [DW-1:0] o_spi_rdata;
    logic          i_owt_vld;
    logic [AW-1:0] i_owt_addr;
    logic [DW-1:0] i_owt_wdata;
    logic [CW-1:0] i_owt_wcrc;
    logic          o_owt_rdy;
    logic          i_chk_rd_req;
    logic [AW-1:0] i_chk_addr;
    logic          o_chk_rack;
    logic [DW-1:0] o_chk_rdata;
    logic          o_rac_wr_req, o_rac_rd_req;
    logic [AW-1:0] o_rac_addr;
    logic [DW-1:0] o_rac_wdata;
    logic [CW-1:0] o_rac_wcrc;
    logic          i_rac_wack, i_rac_rack;
    logic [DW-1:0] i_rac_rdata;
    logic          o_busy, o_to_pulse, o_acc_err;
    logic          i_err_clr;

    hv_rac_req_sched #(
        .REG_AW(AW), .REG_DW(DW), .REG_CRC_W(CW), .TIMEOUT_CYC(16), .TO_W(5)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_spi_wr_req(i_spi_wr_req), .i_spi_rd_req(i_spi_rd_req),
        .i_spi_addr(i_spi_addr), .i_spi_wdata(i_spi_wdata), .i_spi_wcrc(i_spi_wcrc),
        .o_spi_wack(o_spi_wack), .o_spi_rack(o_spi_rack), .o_spi_rdata(o_spi_rdata),
        .i_owt_vld(i_owt_vld), .i_owt_addr(i_owt_addr), .i_owt_wdata(i_owt_wdata),
        .i_owt_wcrc(i_owt_wcrc), .o_owt_rdy(o_owt_rdy),
        .i_chk_rd_req(i_chk_rd_req), .i_chk_addr(i_chk_addr),
        .o_chk_rack(o_chk_rack), .o_chk_rdata(o_chk_rdata),
        .o_rac_wr_req(o_rac_wr_req), .o_rac_rd_req(o_rac_rd_req),
        .o_rac_addr(o_rac_addr), .o_rac_wdata(o_rac_wdata), .o_rac_wcrc(o_rac_wcrc),
        .i_rac_wack(i_rac_wack), .i_rac_rack(i_rac_rack), .i_rac_rdata(i_rac_rdata),
        .o_busy(o_busy), .o_to_pulse(o_to_pulse), .o_acc_err(o_acc_err),
        .i_err_clr(i_err_clr)
    );

    // Clock and watchdog
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        logic          spi_wr, spi_rd, owt, chk;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [CW-1:0] wcrc;
        logic [DW-1:0] rdata;
        int            dly;
        logic          drop;
        logic [3:0]    exp_acks;   // {spi_wack, spi_rack, owt_rdy, chk_rack}
        logic [DW-1:0] exp_srd;
        logic [DW-1:0] exp_crd;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [EW-1:0] pack_txn(logic wr, logic rd, logic [AW-1:0] a,
                                               logic [DW-1:0] d, logic [CW-1:0] c);
        return {wr, rd, a, d, c};
    endfunction

    function automatic vec_t mk(logic sw, logic sr, logic ow, logic ck, logic [AW-1:0] a,
                                logic [DW-1:0] d, logic [CW-1:0] c, logic [DW-1:0] rd,
                                int dly, logic drop, logic [3:0] acks,
                                logic [DW-1:0] srd, logic [DW-1:0] crd);
        vec_t v;
        v.spi_wr = sw; v.spi_rd = sr; v.owt = ow; v.chk = ck;
        v.addr = a; v.wdata = d; v.wcrc = c; v.rdata = rd;
        v.dly = dly; v.drop = drop; v.exp_acks = acks;
        v.exp_srd = srd; v.exp_crd = crd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge i_clk);
    endtask

    task automatic drop_reqs();
        i_spi_wr_req = 1'b0; i_spi_rd_req = 1'b0; i_owt_vld = 1'b0; i_chk_rd_req = 1'b0;
    endtask

    task automatic clear_inputs();
        drop_reqs();
        i_spi_addr = '0; i_spi_wdata = '0; i_spi_wcrc = '0;
        i_owt_addr = '0; i_owt_wdata = '0; i_owt_wcrc = '0;
        i_chk_addr = '0;
        i_rac_wack = 1'b0; i_rac_rack = 1'b0; i_rac_rdata = '0;
        i_err_clr = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    // Drive a request set; idle requesters get random field values.
    task automatic drive_req(input logic sw, input logic sr, input logic ow, input logic ck,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [CW-1:0] c);
        i_spi_wr_req = sw; i_spi_rd_req = sr; i_owt_vld = ow; i_chk_rd_req = ck;
        i_spi_addr  = (sw | sr) ? a : AW'($urandom_range(0, 127));
        i_spi_wdata = (sw | sr) ? d : DW'($urandom_range(0, 255));
        i_spi_wcrc  = (sw | sr) ? c : CW'($urandom_range(0, 255));
        i_owt_addr  = ow ? a : AW'($urandom_range(0, 127));
        i_owt_wdata = ow ? d : DW'($urandom_range(0, 255));
        i_owt_wcrc  = ow ? c : CW'($urandom_range(0, 255));
        i_chk_addr  = ck ? a : AW'($urandom_range(0, 127));
    endtask

    // Wait (bounded) for a RAC request, check one-cycle grant latency, then
    // compare it against the scoreboard head.
    task automatic wait_req(input string name);
        int lat;
        bit found;
        lat = 0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            at_neg();
            if (o_rac_wr_req | o_rac_rd_req) begin
                found = 1'b1;
                break;
            end
            step();
            lat++;
        end
        check({name, "_lat"}, found ? 64'(lat) : 64'hdead, 64'd1);
        if (found) begin
            if (exp_q.size() == 0) begin
                check({name, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check({name, "_rac"}, 64'(pack_txn(o_rac_wr_req, o_rac_rd_req, o_rac_addr,
                                                   o_rac_wdata, o_rac_wcrc)), 64'(e));
            end
        end
    endtask

    // RAC model: ack dly cycles after the request appeared, then check routing.
    task automatic serve(input string name, input int dly, input logic wk, input logic rk,
                         input logic [DW-1:0] rdata, input logic drop, input logic [3:0] acks,
                         input logic [DW-1:0] srd, input logic [DW-1:0] crd);
        for (int k = 0; k < dly; k++) begin
            step();
            if (drop && k == 0) drop_reqs();
        end
        check({name, "_busy"}, 64'(o_busy), 64'd1);
        i_rac_wack = wk; i_rac_rack = rk; i_rac_rdata = rdata;
        at_neg();
        check({name, "_acks"}, 64'({o_spi_wack, o_spi_rack, o_owt_rdy, o_chk_rack}), 64'(acks));
        check({name, "_rdata"}, 64'({o_spi_rdata, o_chk_rdata}), 64'({srd, crd}));
        check({name, "_nto"}, 64'({o_to_pulse, o_acc_err}), 64'd0);
        step();
        i_rac_wack = 1'b0; i_rac_rack = 1'b0; i_rac_rdata = '0;
    endtask

    task automatic idle_check(input string name);
        at_neg();
        check({name, "_idle"}, 64'({o_rac_wr_req, o_rac_rd_req, o_busy, o_spi_wack,
                                    o_spi_rack, o_owt_rdy, o_chk_rack}), 64'd0);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({o_spi_wack, o_spi_rack, o_spi_rdata, o_owt_rdy, o_chk_rack, o_chk_rdata,
                    o_rac_wr_req, o_rac_rd_req, o_rac_addr, o_rac_wdata, o_rac_wcrc,
                    o_busy, o_to_pulse, o_acc_err});
    endfunction

    initial begin
        logic wr;
        int bad;

        vecs[0] = mk(1, 0, 0, 0, 7'h12, 8'hA5, 8'h5A, 8'h77, 3, 0, 4'b1000, 8'h00, 8'h00);
        vecs[1] = mk(0, 0, 0, 1, 7'h40, 8'hFF, 8'hFF, 8'h3C, 2, 0, 4'b0001, 8'h00, 8'h3C);
        vecs[2] = mk(0, 0, 1, 0, 7'h33, 8'hC3, 8'h1E, 8'h00, 1, 0, 4'b0010, 8'h00, 8'h00);
        vecs[3] = mk(0, 1, 0, 0, 7'h7F, 8'h81, 8'h18, 8'h96, 4, 0, 4'b0100, 8'h96, 8'h00);
        vecs[4] = mk(0, 1, 0, 0, 7'h00, 8'h00, 8'h00, 8'h5A, 2, 1, 4'b0100, 8'h5A, 8'h00);
        vecs[5] = mk(0, 0, 1, 0, 7'h01, 8'h00, 8'hFF, 8'h00, 5, 1, 4'b0010, 8'h00, 8'h00);

        // Reset state
        i_rst_n = 1'b0;
        clear_inputs();
        #12;
        check("reset_outs", all_outs(), 64'd0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Acks in IDLE are never forwarded
        i_rac_wack = 1'b1; i_rac_rack = 1'b1; i_rac_rdata = 8'hFF;
        at_neg();
        check("idle_ack", all_outs(), 64'd0);
        step();
        clear_inputs();
        step();

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            wr = vecs[i].spi_wr | vecs[i].owt;
            drive_req(vecs[i].spi_wr, vecs[i].spi_rd, vecs[i].owt, vecs[i].chk,
                      vecs[i].addr, vecs[i].wdata, vecs[i].wcrc);
            exp_q.push_back(pack_txn(wr, ~wr, vecs[i].addr, wr ? vecs[i].wdata : 8'h00,
                                     wr ? vecs[i].wcrc : 8'h00));
            wait_req($sformatf("vec%0d", i));
            serve($sformatf("vec%0d", i), vecs[i].dly, wr, ~wr, vecs[i].rdata, vecs[i].drop,
                  vecs[i].exp_acks, vecs[i].exp_srd, vecs[i].exp_crd);
            drop_reqs();
            idle_check($sformatf("vec%0d", i));
            step();
        end

        // Round-robin from reset: SPI, OWT, CHK, SPI
        do_reset();
        i_spi_rd_req = 1'b1; i_spi_addr = 7'h0A;
        i_owt_vld = 1'b1; i_owt_addr = 7'h0B; i_owt_wdata = 8'hBB; i_owt_wcrc = 8'hB0;
        i_chk_rd_req = 1'b1; i_chk_addr = 7'h0C;
        exp_q.push_back(pack_txn(0, 1, 7'h0A, 8'h00, 8'h00));
        exp_q.push_back(pack_txn(1, 0, 7'h0B, 8'hBB, 8'hB0));
        exp_q.push_back(pack_txn(0, 1, 7'h0C, 8'h00, 8'h00));
        exp_q.push_back(pack_txn(0, 1, 7'h0A, 8'h00, 8'h00));
        wait_req("rr0"); serve("rr0", 2, 0, 1, 8'h11, 0, 4'b0100, 8'h11, 8'h00);
        wait_req("rr1"); serve("rr1", 2, 1, 0, 8'h00, 0, 4'b0010, 8'h00, 8'h00);
        wait_req("rr2"); serve("rr2", 2, 0, 1, 8'h22, 0, 4'b0001, 8'h00, 8'h22);
        wait_req("rr3"); serve("rr3", 2, 0, 1, 8'h33, 0, 4'b0100, 8'h33, 8'h00);
        drop_reqs();
        idle_check("rr");
        step();

        // OWT write timeout, then clear the sticky error
        drive_req(0, 0, 1, 0, 7'h55, 8'h66, 8'h77);
        exp_q.push_back(pack_txn(1, 0, 7'h55, 8'h66, 8'h77));
        wait_req("to");
        step();
        drop_reqs();
        bad = 0;
        for (int k = 1; k < 15; k++) begin
            at_neg();
            if (o_owt_rdy || o_to_pulse || o_acc_err || !o_busy) bad++;
            step();
        end
        check("to_early", 64'(bad), 64'd0);
        at_neg();
        check("to_fire", 64'({o_owt_rdy, o_to_pulse, o_acc_err, o_spi_wack, o_spi_rack,
                              o_chk_rack, o_rac_wr_req}), 64'b1110001);
        step();
        at_neg();
        check("to_after", 64'({o_rac_wr_req, o_busy, o_to_pulse, o_owt_rdy, o_acc_err}),
              64'b00001);
        step();
        i_err_clr = 1'b1;
        step();
        i_err_clr = 1'b0;
        at_neg();
        check("err_clr", 64'(o_acc_err), 64'd0);
        step();

        // CHK read timeout with clear held: set wins, rdata forced to zero
        drive_req(0, 0, 0, 1, 7'h2A, 8'h00, 8'h00);
        i_err_clr = 1'b1;
        i_rac_rdata = 8'hEE;
        exp_q.push_back(pack_txn(0, 1, 7'h2A, 8'h00, 8'h00));
        wait_req("setwin");
        step();
        drop_reqs();
        for (int k = 1; k < 15; k++) step();
        at_neg();
        check("setwin_fire", 64'({o_chk_rack, o_to_pulse, o_acc_err, o_chk_rdata}),
              64'({3'b111, 8'h00}));
        step();
        i_err_clr = 1'b0;
        at_neg();
        check("setwin_sticky", 64'(o_acc_err), 64'd1);
        step();
        i_err_clr = 1'b1;
        i_rac_rdata = '0;
        step();
        i_err_clr = 1'b0;
        idle_check("setwin");
        step();

        // SPI wr+rd together: rack ignored, write first, then the read
        drive_req(1, 1, 0, 0, 7'h21, 8'h5C, 8'h99);
        exp_q.push_back(pack_txn(1, 0, 7'h21, 8'h5C, 8'h99));
        exp_q.push_back(pack_txn(0, 1, 7'h21, 8'h00, 8'h00));
        wait_req("wrrd_w");
        step();
        i_rac_rack = 1'b1; i_rac_rdata = 8'hAB;
        at_neg();
        check("wrrd_rack_ign", 64'({o_spi_wack, o_spi_rack, o_owt_rdy, o_chk_rack, o_busy,
                                    o_spi_rdata}), 64'({5'b00001, 8'h00}));
        step();
        i_rac_rack = 1'b0; i_rac_rdata = '0; i_rac_wack = 1'b1;
        at_neg();
        check("wrrd_wack", 64'({o_spi_wack, o_spi_rack, o_owt_rdy, o_chk_rack}), 64'b1000);
        step();
        i_rac_wack = 1'b0;
        i_spi_wr_req = 1'b0;
        wait_req("wrrd_r");
        serve("wrrd_r", 1, 0, 1, 8'h42, 0, 4'b0100, 8'h42, 8'h00);
        drop_reqs();
        idle_check("wrrd");
        step();

        // Async reset mid-ACC, then SPI wins first after release
        drive_req(1, 0, 0, 0, 7'h31, 8'h13, 8'h44);
        exp_q.push_back(pack_txn(1, 0, 7'h31, 8'h13, 8'h44));
        wait_req("rst_pre");
        step();
        i_rst_n = 1'b0;
        i_rac_wack = 1'b1;
        i_owt_vld = 1'b1; i_owt_addr = 7'h32; i_owt_wdata = 8'h23; i_owt_wcrc = 8'h45;
        #1;
        check("rst_mid", all_outs(), 64'd0);
        step();
        step();
        i_rac_wack = 1'b0;
        exp_q.push_back(pack_txn(1, 0, 7'h31, 8'h13, 8'h44));
        exp_q.push_back(pack_txn(1, 0, 7'h32, 8'h23, 8'h45));
        i_rst_n = 1'b1;
        wait_req("rst_spi");
        serve("rst_spi", 1, 1, 0, 8'h00, 0, 4'b1000, 8'h00, 8'h00);
        i_spi_wr_req = 1'b0;
        wait_req("rst_owt");
        serve("rst_owt", 1, 1, 0, 8'h00, 0, 4'b0010, 8'h00, 8'h00);
        drop_reqs();
        idle_check("rst");
        step();

        check("sb_drained", 64'(exp_q.size()), 64'd0);

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
